// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - load/store unit: one req/gnt/rvalid data-memory access per START
module core_lsu #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_FLW,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic        I_FSW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGN,
    output logic        FAULT
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FIN} state_t;

    localparam int unsigned CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t state, state_nx;

    logic          op_load, op_store, any_op;
    logic          op_byte, op_half, op_signed;
    logic          addr_mis, start_ok, tmo_hit;
    logic          fault_nx, mis_nx;
    logic [3:0]    st_strb;
    logic [31:0]   st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_ext;

    logic          store_q, byte_q, half_q, signed_q;
    logic [1:0]    lane_q;
    logic [CW-1:0] tmo_cnt;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q, load_q;
    logic [3:0]    mem_wstrb_q;
    logic          fault_q, mis_q;

    assign op_load   = I_LB | I_LH | I_LW | I_LBU | I_LHU | I_FLW;
    assign op_store  = I_SB | I_SH | I_SW | I_FSW;
    assign any_op    = op_load | op_store;
    assign op_byte   = I_LB | I_LBU | I_SB;
    assign op_half   = I_LH | I_LHU | I_SH;
    assign op_signed = I_LB | I_LH;
    assign addr_mis  = (op_half & ADDR[0]) |
                       (~op_byte & ~op_half & (ADDR[1:0] != 2'b00));
    assign start_ok  = START & any_op & (state == S_IDLE);

    // Counter is zero in the first REQ cycle, so the TIMEOUT-th REQ/WAIT cycle sees TIMEOUT-1.
    assign tmo_hit = (TIMEOUT != 0) && ({{(32-CW){1'b0}}, tmo_cnt} >= TMO_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fault_nx = 1'b0;
        mis_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    if (addr_mis) begin
                        state_nx = S_FIN;
                        mis_nx   = 1'b1;
                    end else begin
                        state_nx = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (MEM_GNT) begin
                    state_nx = store_q ? S_FIN : S_WAIT;
                end else if (tmo_hit) begin
                    state_nx = S_FIN;
                    fault_nx = 1'b1;
                end
            end
            S_WAIT: begin
                if (MEM_RVALID) begin
                    state_nx = S_FIN;
                end else if (tmo_hit) begin
                    state_nx = S_FIN;
                    fault_nx = 1'b1;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != S_IDLE);
        DONE = (state == S_FIN);
    end

    always_comb begin
        st_strb  = 4'b0000;
        st_wdata = 32'h0;
        if (op_store) begin
            if (op_byte) begin
                st_wdata = {4{WDATA[7:0]}};
                st_strb  = 4'b0001 << ADDR[1:0];
            end else if (op_half) begin
                st_wdata = {2{WDATA[15:0]}};
                st_strb  = ADDR[1] ? 4'b1100 : 4'b0011;
            end else begin
                st_wdata = WDATA;
                st_strb  = 4'b1111;
            end
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = MEM_RDATA[7:0];
            2'd1:    ld_byte = MEM_RDATA[15:8];
            2'd2:    ld_byte = MEM_RDATA[23:16];
            default: ld_byte = MEM_RDATA[31:24];
        endcase
        ld_half = lane_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        if (byte_q) begin
            load_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
        end else if (half_q) begin
            load_ext = {{16{signed_q & ld_half[15]}}, ld_half};
        end else begin
            load_ext = MEM_RDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            store_q     <= 1'b0;
            byte_q      <= 1'b0;
            half_q      <= 1'b0;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            tmo_cnt     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
            load_q      <= 32'h0;
            fault_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            mem_req_q <= (state_nx == S_REQ);
            fault_q   <= fault_nx;
            mis_q     <= mis_nx;
            if (start_ok) begin
                store_q  <= op_store;
                byte_q   <= op_byte;
                half_q   <= op_half;
                signed_q <= op_signed;
                lane_q   <= ADDR[1:0];
                tmo_cnt  <= '0;
                // A misaligned access never reaches the bus, so the bus view is left as it was.
                if (!addr_mis) begin
                    mem_we_q    <= op_store;
                    mem_addr_q  <= {ADDR[31:2], 2'b00};
                    mem_wstrb_q <= st_strb;
                    mem_wdata_q <= st_wdata;
                end
            end else if (state == S_REQ || state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (state == S_WAIT && MEM_RVALID) begin
                load_q <= load_ext;
            end
        end
    end

    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WSTRB = mem_wstrb_q;
    assign MEM_WDATA = mem_wdata_q;
    assign LOAD_DATA = load_q;
    assign MISALIGN  = mis_q;
    assign FAULT     = fault_q;

endmodule

// File: tb/tb_core_lsu.sv
// tb/tb_core_lsu.sv - self-checking bench for core_lsu: vector table, random model, corner sequences
module tb_core_lsu;

    localparam int TMO = 8;
    localparam int OP_LB = 0, OP_LH = 1, OP_LW = 2, OP_LBU = 3, OP_LHU = 4, OP_FLW = 5;
    localparam int OP_SB = 6, OP_SH = 7, OP_SW = 8, OP_FSW = 9;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [9:0]  flags = '0;
    logic [31:0] ADDR = '0;
    logic [31:0] WDATA = '0;
    logic        MEM_GNT = 1'b0;
    logic        MEM_RVALID = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_REQ, MEM_WE, BUSY, DONE, MISALIGN, FAULT;
    logic [31:0] MEM_ADDR, MEM_WDATA, LOAD_DATA;
    logic [3:0]  MEM_WSTRB;

    core_lsu #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .I_LB(flags[0]), .I_LH(flags[1]), .I_LW(flags[2]), .I_LBU(flags[3]),
        .I_LHU(flags[4]), .I_FLW(flags[5]), .I_SB(flags[6]), .I_SH(flags[7]),
        .I_SW(flags[8]), .I_FSW(flags[9]),
        .ADDR(ADDR), .WDATA(WDATA),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA),
        .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY), .DONE(DONE), .LOAD_DATA(LOAD_DATA),
        .MISALIGN(MISALIGN), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          done_cyc;
        int          req_cnt;
        logic        stable;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  strb;
        logic        mis;
        logic        flt;
        logic [31:0] ld;
    } res_t;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dg;
        int          dr;
        int          mid;
        int          e_done;
        logic        e_mis;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] ld_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one access and plays the memory side: GNT after dg REQ cycles, RVALID after dr WAIT cycles.
    task automatic run_access(input int op, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int dg, input int dr, input int mid,
                              output res_t r);
        logic granted;
        int   wc;
        r = '{done_cyc: -1, req_cnt: 0, stable: 1'b1, we: 1'b0, maddr: '0, mwdata: '0,
              strb: '0, mis: 1'b0, flt: 1'b0, ld: '0};
        granted = 1'b0;
        wc = 0;
        flags = 10'(1 << op);
        START = 1'b1;
        ADDR  = addr;
        WDATA = wd;
        step();
        for (int c = 1; c <= 40 && r.done_cyc < 0; c++) begin
            START = 1'b0;
            flags = '0;
            ADDR  = $urandom;
            WDATA = $urandom;
            MEM_GNT = 1'b0;
            MEM_RVALID = 1'b0;
            MEM_RDATA = $urandom;
            if (c == mid) begin
                START = 1'b1;
                flags = 10'(1 << OP_LW);
                ADDR  = 32'h0000_0F00;
            end
            if (DONE) begin
                r.done_cyc = c;
                r.mis = MISALIGN;
                r.flt = FAULT;
                r.ld  = LOAD_DATA;
                MEM_RVALID = 1'($urandom_range(0, 1));
            end else if (MEM_REQ) begin
                if (r.req_cnt == 0) begin
                    r.we = MEM_WE; r.maddr = MEM_ADDR; r.mwdata = MEM_WDATA; r.strb = MEM_WSTRB;
                end else if (MEM_WE !== r.we || MEM_ADDR !== r.maddr ||
                             MEM_WDATA !== r.mwdata || MEM_WSTRB !== r.strb) begin
                    r.stable = 1'b0;
                end
                if (r.req_cnt == dg) begin
                    MEM_GNT = 1'b1;
                    granted = 1'b1;
                end else begin
                    MEM_RVALID = 1'($urandom_range(0, 1));
                end
                r.req_cnt++;
            end else if (granted && BUSY) begin
                if (wc == dr) begin
                    MEM_RVALID = 1'b1;
                    MEM_RDATA = rd;
                end
                wc++;
            end
            step();
        end
        START = 1'b0; flags = '0; MEM_GNT = 1'b0; MEM_RVALID = 1'b0;
    endtask

    task automatic verify(input string tag, input res_t r, input int e_done, input int e_req,
                          input logic e_st, input logic e_mis, input logic e_flt,
                          input logic [31:0] e_addr, input logic [31:0] e_wd,
                          input logic [3:0] e_strb, input logic [31:0] e_ld);
        check({tag, " done_cycle"}, 32'(r.done_cyc), 32'(e_done));
        check({tag, " misalign"}, 32'(r.mis), 32'(e_mis));
        check({tag, " fault"}, 32'(r.flt), 32'(e_flt));
        check({tag, " req_cycles"}, 32'(r.req_cnt), 32'(e_req));
        check({tag, " load_data"}, r.ld, e_ld);
        if (e_req > 0) begin
            check({tag, " req_stable"}, 32'(r.stable), 32'd1);
            check({tag, " mem_we"}, 32'(r.we), 32'(e_st));
            check({tag, " mem_addr"}, r.maddr, e_addr);
            check({tag, " mem_wstrb"}, 32'(r.strb), 32'(e_strb));
            check({tag, " mem_wdata"}, r.mwdata, e_wd);
        end
        check({tag, " idle_after"}, 32'({BUSY, MEM_REQ, DONE}), 32'd0);
    endtask

    // Reference: access size decides alignment, lane mask, replication and extension.
    function automatic void model(input int op, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rd, input logic [31:0] ld_prev,
                                  output logic mis, output logic [3:0] strb,
                                  output logic [31:0] wdat, output logic [31:0] ld);
        int size, lane;
        logic [31:0] mask, v;
        bit is_st, sgn;
        is_st = (op >= OP_SB);
        size  = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
                (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        sgn   = (op == OP_LB || op == OP_LH);
        mis   = (int'(addr[1:0]) % size) != 0;
        lane  = int'(addr[1:0]);
        mask  = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
        strb  = '0;
        wdat  = '0;
        ld    = ld_prev;
        if (is_st && !mis) begin
            strb = 4'(((1 << size) - 1) << lane);
            wdat = (wd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
        end
        if (!is_st && !mis) begin
            v = (rd >> (8 * lane)) & mask;
            if (sgn && v[8 * size - 1]) v = v | ~mask;
            ld = v;
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        res_t r;
        logic        m_mis;
        logic [3:0]  m_strb;
        logic [31:0] m_wd, m_ld;

        vecs[0]  = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 3, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{OP_LB,  32'h103, 32'h0,        32'h80123456, 0, 0, 0, 3, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{OP_LBU, 32'h103, 32'h0,        32'h80654321, 0, 0, 0, 3, 1'b0, 4'b0000, 32'h0,        32'h00000080};
        vecs[3]  = '{OP_SB,  32'h102, 32'h000000AB, 32'h0,        0, 0, 0, 2, 1'b0, 4'b0100, 32'hABABABAB, 32'h00000080};
        vecs[4]  = '{OP_SH,  32'h101, 32'h00001234, 32'h0,        0, 0, 0, 1, 1'b1, 4'b0000, 32'h0,        32'h00000080};
        vecs[5]  = '{OP_LH,  32'h102, 32'h0,        32'h80015555, 1, 2, 0, 6, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{OP_LHU, 32'h100, 32'h0,        32'h1234F00D, 0, 1, 0, 4, 1'b0, 4'b0000, 32'h0,        32'h0000F00D};
        vecs[7]  = '{OP_SH,  32'h106, 32'h0000BEEF, 32'h0,        2, 0, 0, 4, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0000F00D};
        vecs[8]  = '{OP_SW,  32'h104, 32'h12345678, 32'h0,        5, 0, 3, 7, 1'b0, 4'b1111, 32'h12345678, 32'h0000F00D};
        vecs[9]  = '{OP_LW,  32'h102, 32'h0,        32'h0,        0, 0, 0, 1, 1'b1, 4'b0000, 32'h0,        32'h0000F00D};
        vecs[10] = '{OP_FLW, 32'h108, 32'h0,        32'hCAFEF00D, 0, 0, 0, 3, 1'b0, 4'b0000, 32'h0,        32'hCAFEF00D};
        vecs[11] = '{OP_FSW, 32'h10C, 32'hA5A55A5A, 32'h0,        1, 0, 0, 3, 1'b0, 4'b1111, 32'hA5A55A5A, 32'hCAFEF00D};
        vecs[12] = '{OP_LB,  32'h101, 32'h0,        32'h00007F00, 0, 0, 0, 3, 1'b0, 4'b0000, 32'h0,        32'h0000007F};
        vecs[13] = '{OP_LH,  32'h103, 32'h0,        32'h0,        0, 0, 0, 1, 1'b1, 4'b0000, 32'h0,        32'h0000007F};

        RST_N = 1'b0;
        repeat (3) step();
        check("reset bus", 32'({MEM_REQ, MEM_WE, MEM_WSTRB}), 32'd0);
        check("reset mem_addr", MEM_ADDR, 32'd0);
        check("reset mem_wdata", MEM_WDATA, 32'd0);
        check("reset status", 32'({BUSY, DONE, MISALIGN, FAULT}), 32'd0);
        check("reset load_data", LOAD_DATA, 32'd0);
        RST_N = 1'b1;
        step();

        foreach (vecs[i]) begin
            run_access(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].rd,
                       vecs[i].dg, vecs[i].dr, vecs[i].mid, r);
            verify($sformatf("vec%0d", i), r, vecs[i].e_done, vecs[i].e_mis ? 0 : vecs[i].dg + 1,
                   1'(vecs[i].op >= OP_SB), vecs[i].e_mis, 1'b0, vecs[i].addr & 32'hFFFF_FFFC,
                   vecs[i].e_wd, vecs[i].e_strb, vecs[i].e_ld);
            ld_model = vecs[i].e_ld;
        end

        for (int k = 0; k < 40; k++) begin
            int op, dg, dr;
            logic [31:0] a, wd, rd;
            op = $urandom_range(0, 9);
            dg = $urandom_range(0, 3);
            dr = $urandom_range(0, 2);
            a  = 32'h1000 + 32'($urandom_range(0, 255));
            wd = $urandom;
            rd = $urandom;
            model(op, a, wd, rd, ld_model, m_mis, m_strb, m_wd, m_ld);
            run_access(op, a, wd, rd, dg, dr, 0, r);
            verify($sformatf("rand%0d", k), r,
                   m_mis ? 1 : (op >= OP_SB) ? dg + 2 : dg + dr + 3,
                   m_mis ? 0 : dg + 1, 1'(op >= OP_SB), m_mis, 1'b0,
                   a & 32'hFFFF_FFFC, m_wd, m_strb, m_ld);
            ld_model = m_ld;
        end

        run_access(OP_LW, 32'h200, 32'h0, 32'h0, 0, 1000, 0, r);
        verify("tmo_load", r, TMO + 1, 1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 4'b0000, ld_model);
        MEM_RVALID = 1'b1;
        MEM_RDATA = 32'h1111_1111;
        step();
        step();
        MEM_RVALID = 1'b0;
        check("late rvalid load_data", LOAD_DATA, ld_model);
        check("late rvalid status", 32'({BUSY, DONE, FAULT}), 32'd0);

        run_access(OP_SW, 32'h204, 32'h5555AAAA, 32'h0, 1000, 0, 0, r);
        verify("tmo_store", r, TMO + 1, TMO, 1'b1, 1'b0, 1'b1, 32'h204, 32'h5555AAAA, 4'b1111, ld_model);

        START = 1'b1;
        flags = '0;
        ADDR = 32'h300;
        step();
        START = 1'b0;
        check("noflag idle", 32'({BUSY, MEM_REQ}), 32'd0);
        step();
        check("noflag no done", 32'({DONE, MISALIGN}), 32'd0);

        START = 1'b1;
        flags = 10'(1 << OP_LW);
        ADDR = 32'h400;
        step();
        START = 1'b0;
        flags = '0;
        check("rst_mid req up", 32'(MEM_REQ), 32'd1);
        RST_N = 1'b0;
        step();
        check("rst_mid req dropped", 32'({MEM_REQ, BUSY}), 32'd0);
        check("rst_mid load_data", LOAD_DATA, 32'd0);
        RST_N = 1'b1;
        MEM_RVALID = 1'b1;
        MEM_RDATA = 32'hFFFF_FFFF;
        step();
        step();
        MEM_RVALID = 1'b0;
        check("rst_mid late rvalid", LOAD_DATA, 32'd0);
        check("rst_mid no done", 32'({DONE, BUSY}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
